dht11_scheduler: RTL and testbench

Sequences the existing DHT11 reader in the cold-storage sensor path. It gates the reader's en input and enforces the sensor's minimum inter-read gap. It runs periodic and on-demand reads, applies a timeout and bounded retries, and rejects invalid frames. Accepted samples go to downstream logic (display/control) over a valid/ack handshake.

---
 rtl/dht11_pkg.sv | 23 ++
 rtl/dht11_sat_counter.sv | 25 ++
 rtl/dht11_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_dht11_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared types and default timing constants for the DHT11 read scheduler.
package dht11_pkg;

    localparam int DATA_W      = 8;
    localparam int CLK_HZ      = 1_000_000;
    localparam int PERIOD_CYC  = 2_000_000;
    localparam int MIN_GAP_CYC = 1_000_000;
    localparam int TIMEOUT_CYC = 30_000;
    localparam int MAX_RETRY   = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        READ,
        EVAL
    } state_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dht11_sat_counter.sv
// Up-counter that saturates at MAX_VAL; synchronous clear wins over increment.
module dht11_sat_counter #(
    parameter int             MAX_VAL = 15,
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX_VAL))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_scheduler.sv
// Sequences the DHT11 reader: periodic/on-demand chains, gap enforcement, timeout, retries.
// Optional threshold alarms are built when DHT11_SCHED_ALARM_EN is defined.
module dht11_scheduler #(
    parameter int PERIOD_CYC  = dht11_pkg::PERIOD_CYC,
    parameter int MIN_GAP_CYC = dht11_pkg::MIN_GAP_CYC,
    parameter int TIMEOUT_CYC = dht11_pkg::TIMEOUT_CYC,
    parameter int MAX_RETRY   = dht11_pkg::MAX_RETRY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         trig,
    output logic                         rd_en,
    input  logic                         rd_data_ready,
    input  logic [dht11_pkg::DATA_W-1:0] rd_humidity,
    input  logic [dht11_pkg::DATA_W-1:0] rd_temperature,
    output logic [dht11_pkg::DATA_W-1:0] humidity,
    output logic [dht11_pkg::DATA_W-1:0] temperature,
    output logic                         sample_valid,
    input  logic                         sample_ack,
    output logic                         overrun,
    output logic                         fault,
    output logic                         busy,
    input  logic [dht11_pkg::DATA_W-1:0] t_hi,
    input  logic [dht11_pkg::DATA_W-1:0] t_lo,
    output logic                         alarm_hi,
    output logic                         alarm_lo
);

    import dht11_pkg::*;

    localparam int GAP_W = cnt_w(MIN_GAP_CYC);
    localparam int PER_W = cnt_w(PERIOD_CYC - 1);
    localparam int TMO_W = cnt_w(TIMEOUT_CYC - 1);
    localparam int RTY_W = cnt_w(MAX_RETRY);

    state_t              state;
    logic [GAP_W-1:0]    gap_cnt;
    logic [PER_W-1:0]    period_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [RTY_W-1:0]    retry_cnt;
    logic                trig_pend;
    logic                ok;
    logic [DATA_W-1:0]   stg_hum;
    logic [DATA_W-1:0]   stg_temp;

    logic gap_done;
    logic period_due;
    logic tmo_last;
    logic frame_valid;
    logic start_chain;
    logic rd_rise;
    logic accept;

    assign gap_done    = gap_cnt >= GAP_W'(MIN_GAP_CYC);
    assign period_due  = period_cnt == PER_W'(PERIOD_CYC - 1);
    assign tmo_last    = tmo_cnt == TMO_W'(TIMEOUT_CYC - 1);
    // The reader leaves 0/0 behind on a checksum failure.
    assign frame_valid = !((stg_hum == '0) && (stg_temp == '0));
    assign start_chain = enable && (state == IDLE) && (period_due || trig_pend);
    assign rd_rise     = enable && (state == HOLD) && gap_done;
    assign accept      = enable && (state == EVAL) && ok && frame_valid;

    dht11_sat_counter #(.MAX_VAL(MIN_GAP_CYC), .W(GAP_W), .RST_VAL('0)) u_gap (
        .clk(clk), .rst(rst), .clr(rd_rise), .inc(!rd_en), .cnt(gap_cnt)
    );

    // Resets to its terminal value so the first chain starts right after power-up settle.
    dht11_sat_counter #(.MAX_VAL(PERIOD_CYC - 1), .W(PER_W), .RST_VAL(PER_W'(PERIOD_CYC - 1))) u_period (
        .clk(clk), .rst(rst), .clr(start_chain), .inc(1'b1), .cnt(period_cnt)
    );

    dht11_sat_counter #(.MAX_VAL(TIMEOUT_CYC - 1), .W(TMO_W), .RST_VAL('0)) u_tmo (
        .clk(clk), .rst(rst), .clr(rd_rise), .inc(state == READ), .cnt(tmo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_en        <= 1'b0;
            busy         <= 1'b0;
            trig_pend    <= 1'b0;
            retry_cnt    <= '0;
            ok           <= 1'b0;
            stg_hum      <= '0;
            stg_temp     <= '0;
            humidity     <= '0;
            temperature  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            if (!enable) begin
                state     <= IDLE;
                busy      <= 1'b0;
                rd_en     <= 1'b0;
                trig_pend <= 1'b0;
                retry_cnt <= '0;
            end else begin
                // A trig coinciding with chain start stays pending rather than being lost.
                if (trig) begin
                    trig_pend <= 1'b1;
                end else if (start_chain) begin
                    trig_pend <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (period_due || trig_pend) begin
                            state <= HOLD;
                            busy  <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (gap_done) begin
                            rd_en <= 1'b1;
                            state <= READ;
                        end
                    end
                    READ: begin
                        if (rd_data_ready) begin
                            stg_hum  <= rd_humidity;
                            stg_temp <= rd_temperature;
                            ok       <= 1'b1;
                            rd_en    <= 1'b0;
                            state    <= EVAL;
                        end else if (tmo_last) begin
                            ok    <= 1'b0;
                            rd_en <= 1'b0;
                            state <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (ok && frame_valid) begin
                            humidity    <= stg_hum;
                            temperature <= stg_temp;
                            fault       <= 1'b0;
                            retry_cnt   <= '0;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else if ((retry_cnt + 1'b1) == RTY_W'(MAX_RETRY)) begin
                            fault     <= 1'b1;
                            retry_cnt <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= HOLD;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            // An ack landing with a new sample consumes the old one; overrun is left as is.
            if (accept) begin
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ack) begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ack) begin
                sample_valid <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

`ifdef DHT11_SCHED_ALARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else if (accept) begin
            alarm_hi <= stg_temp > t_hi;
            alarm_lo <= stg_temp < t_lo;
        end
    end
`else
    logic unused_thresholds;
    assign unused_thresholds = ^{t_hi, t_lo};
    assign alarm_hi = 1'b0;
    assign alarm_lo = 1'b0;
`endif

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed bench for dht11_scheduler with a behavioural DHT11 reader model.
module tb_dht11_scheduler;

    localparam int PER  = 200;
    localparam int GAP  = 50;
    localparam int TMO  = 100;
    localparam int RESP = 20;

`ifdef DHT11_SCHED_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] h;
        logic [7:0] t;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       trig;
    logic       rd_en;
    logic       rd_data_ready;
    logic [7:0] rd_humidity;
    logic [7:0] rd_temperature;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       sample_valid;
    logic       sample_ack;
    logic       overrun;
    logic       fault;
    logic       busy;
    logic [7:0] t_hi;
    logic [7:0] t_lo;
    logic       alarm_hi;
    logic       alarm_lo;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    c0, r1, f1, r2, f2, r3, f3, r4, f4;
    int    ta, tfa, tb, tfb, tc, tfc, g0, g1, i1, fi1, i2, fi2, s0, s1, x0;
    resp_t resp_q[$];

    dht11_scheduler #(
        .PERIOD_CYC(PER), .MIN_GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig), .rd_en(rd_en),
        .rd_data_ready(rd_data_ready), .rd_humidity(rd_humidity),
        .rd_temperature(rd_temperature), .humidity(humidity), .temperature(temperature),
        .sample_valid(sample_valid), .sample_ack(sample_ack), .overrun(overrun),
        .fault(fault), .busy(busy), .t_hi(t_hi), .t_lo(t_lo),
        .alarm_hi(alarm_hi), .alarm_lo(alarm_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reader model: each rd_en rise consumes one queued response; an empty queue never answers.
    initial begin : reader_model
        resp_t r;
        rd_data_ready  = 1'b0;
        rd_humidity    = 8'h00;
        rd_temperature = 8'h00;
        forever begin
            @(posedge rd_en);
            if (resp_q.size() > 0) begin
                r = resp_q.pop_front();
                repeat (RESP) @(negedge clk);
                if (rd_en === 1'b1) begin
                    rd_humidity    = r.h;
                    rd_temperature = r.t;
                    rd_data_ready  = 1'b1;
                    @(negedge clk);
                    rd_data_ready  = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_en(input logic level, input string tag, output int at);
        int n;
        n = 0;
        while (rd_en !== level && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        at = cyc;
        chk(tag, {31'd0, rd_en}, {31'd0, level});
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        sample_ack = 1'b1;
        @(negedge clk);
        sample_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; trig = 1'b0; sample_ack = 1'b0;
        t_hi = 8'hFF; t_lo = 8'h00;
        resp_q.push_back('{8'h37, 8'h19});
        resp_q.push_back('{8'h38, 8'h1A});
        resp_q.push_back('{8'h39, 8'h1B});
        resp_q.push_back('{8'h3A, 8'h1C});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {rd_en, busy, sample_valid, overrun, fault, alarm_hi, alarm_lo}, 7'd0);
        chk("reset_humidity", humidity, 8'h00);
        chk("reset_temperature", temperature, 8'h00);

        // Power-up: first chain due at once, rd_en waits for the settle gap.
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; c0 = cyc;
        wait_rd_en(1'b1, "rise1", r1);
        chk("rise1_edge", r1 - c0, GAP + 1);
        chk("busy_in_read", busy, 1'b1);
        wait_rd_en(1'b0, "fall1", f1);
        chk("read1_len", f1 - r1, RESP);
        chk("rd_en_low_with_ready", rd_data_ready, 1'b1);
        @(posedge clk); #1;
        chk("s1_humidity", humidity, 8'h37);
        chk("s1_temperature", temperature, 8'h19);
        chk("s1_valid", sample_valid, 1'b1);
        chk("s1_busy", busy, 1'b0);
        chk("s1_alarm_hi", alarm_hi, 1'b0);

        // Periodic chain 2 without ack -> overrun.
        wait_rd_en(1'b1, "rise2", r2);
        chk("rise2_edge", r2 - c0, PER + 2);
        wait_rd_en(1'b0, "fall2", f2);
        @(posedge clk); #1;
        chk("s2_overrun", overrun, 1'b1);
        chk("s2_humidity", humidity, 8'h38);
        chk("s2_valid", sample_valid, 1'b1);
        ack_pulse();
        chk("ack_clears_valid", sample_valid, 1'b0);
        chk("ack_clears_overrun", overrun, 1'b0);

        // Chain 3: period between rises.
        wait_rd_en(1'b1, "rise3", r3);
        chk("period_rise_to_rise", r3 - r2, PER);
        wait_rd_en(1'b0, "fall3", f3);
        @(posedge clk); #1;
        chk("s3_humidity", humidity, 8'h39);
        chk("s3_overrun", overrun, 1'b0);

        // Chain 4: ack coincides with the new sample.
        wait_rd_en(1'b1, "rise4", r4);
        wait_rd_en(1'b0, "fall4", f4);
        sample_ack = 1'b1;
        @(posedge clk); #1;
        sample_ack = 1'b0;
        chk("coincident_valid", sample_valid, 1'b1);
        chk("coincident_overrun", overrun, 1'b0);
        chk("s4_data", {humidity, temperature}, 16'h3A1C);
        ack_pulse();
        chk("s4_acked", sample_valid, 1'b0);

        // Chain 5: reader never answers -> three timeouts then fault.
        wait_rd_en(1'b1, "tmo_rise_a", ta);
        wait_rd_en(1'b0, "tmo_fall_a", tfa);
        chk("tmo_len_a", tfa - ta, TMO);
        wait_rd_en(1'b1, "tmo_rise_b", tb);
        chk("retry_gap_b", tb - tfa, GAP + 1);
        chk("no_fault_mid_chain", fault, 1'b0);
        wait_rd_en(1'b0, "tmo_fall_b", tfb);
        chk("tmo_len_b", tfb - tb, TMO);
        wait_rd_en(1'b1, "tmo_rise_c", tc);
        chk("retry_gap_c", tc - tfb, GAP + 1);
        wait_rd_en(1'b0, "tmo_fall_c", tfc);
        chk("tmo_len_c", tfc - tc, TMO);
        @(posedge clk); #1;
        chk("fault_set", fault, 1'b1);
        chk("fault_busy", busy, 1'b0);
        chk("fault_data_held", {sample_valid, humidity}, 9'h03A);

        // Overdue period restarts immediately; good frame clears fault.
        resp_q.push_back('{8'h41, 8'h2D});
        wait_rd_en(1'b1, "recover_rise", g0);
        chk("recover_gap", g0 - tfc, GAP + 1);
        wait_rd_en(1'b0, "recover_fall", g1);
        @(posedge clk); #1;
        chk("fault_cleared", fault, 1'b0);
        chk("recover_data", {sample_valid, humidity, temperature}, 17'h1412D);

        // trig right after a read waits out the gap; first frame invalid, retry accepted.
        resp_q.push_back('{8'h00, 8'h00});
        resp_q.push_back('{8'h40, 8'h05});
        @(negedge clk);
        trig = 1'b1; sample_ack = 1'b1;
        @(negedge clk);
        trig = 1'b0; sample_ack = 1'b0;
        wait_rd_en(1'b1, "trig_rise", i1);
        chk("trig_deferred", i1 - g1, GAP + 1);
        wait_rd_en(1'b0, "bad_fall", fi1);
        @(posedge clk); #1;
        chk("bad_frame_held", {sample_valid, humidity, temperature}, 17'h0412D);
        chk("bad_frame_retry_busy", busy, 1'b1);
        wait_rd_en(1'b1, "retry_rise", i2);
        chk("bad_retry_gap", i2 - fi1, GAP + 1);
        wait_rd_en(1'b0, "retry_fall", fi2);
        @(posedge clk); #1;
        chk("retry_accept", {sample_valid, humidity, temperature}, 17'h14005);

        // Alarm thresholds on next periodic sample.
        t_hi = 8'h08; t_lo = 8'h02;
        resp_q.push_back('{8'h33, 8'h0A});
        ack_pulse();
        wait_rd_en(1'b1, "alarm_rise", s0);
        wait_rd_en(1'b0, "alarm_fall", s1);
        @(posedge clk); #1;
        chk("alarm_data", {humidity, temperature}, 16'h330A);
        chk("alarm_hi", alarm_hi, ALARM_ON);
        chk("alarm_lo", alarm_lo, 1'b0);

        // Abort: enable low mid-READ.
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        wait_rd_en(1'b1, "abort_rise", x0);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_rd_en", rd_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_held", {sample_valid, humidity, temperature, alarm_hi}, {17'h1330A, ALARM_ON});
        repeat (10) @(posedge clk);
        #1;
        chk("abort_stays_idle", {rd_en, busy}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
